// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port data RAM arbiter.
package ram_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // First of the four memory-mapped PWM registers (1000..1003)
  localparam logic [11:0] PWM_BASE = 12'd1000;
endpackage

// File: rtl/rr_select.sv
// Combinational two-way winner pick: round-robin against last_grant, or fixed port-0 priority.
module rr_select
  import ram_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       any,
  output logic       winner
);
  always_comb begin
    any    = |req;
    winner = PORT0;
    case (req)
      2'b01:   winner = PORT0;
      2'b10:   winner = PORT1;
      2'b11:   winner = (FIXED_PRIO != 0) ? PORT0 : logic'(~last_grant);
      default: winner = PORT0;
    endcase
  end
endmodule

// File: rtl/ram_arbiter.sv
// Serialises two requesters onto the single-port data RAM: IDLE -> ACCESS -> ACK, one transaction per 3 cycles.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int FIXED_PRIO    = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     p0_req,
  input  logic                     p0_wEn,
  input  logic [ADDRESS_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0]    p0_dataIn,
  output logic                     p0_ack,
  output logic [DATA_WIDTH-1:0]    p0_dataOut,
  input  logic                     p1_req,
  input  logic                     p1_wEn,
  input  logic [ADDRESS_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0]    p1_dataIn,
  output logic                     p1_ack,
  output logic [DATA_WIDTH-1:0]    p1_dataOut,
  output logic                     ram_wEn,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_dataIn,
  input  logic [DATA_WIDTH-1:0]    ram_dataOut,
  output logic                     busy
);
  state_t state, state_nxt;
  logic   winner, last_grant, any, pick;

  rr_select #(.FIXED_PRIO(FIXED_PRIO)) u_sel (
    .req       ({p1_req, p0_req}),
    .last_grant(last_grant),
    .any       (any),
    .winner    (pick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any) state_nxt = ACCESS;
      ACCESS:  state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb busy = (state != IDLE);

  // Datapath: the command is latched at the granting edge, so later changes on the port are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      winner     <= PORT0;
      last_grant <= PORT1;
      ram_wEn    <= 1'b0;
      ram_addr   <= '0;
      ram_dataIn <= '0;
      p0_ack     <= 1'b0;
      p1_ack     <= 1'b0;
      p0_dataOut <= '0;
      p1_dataOut <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            winner     <= pick;
            last_grant <= pick;
            ram_wEn    <= pick ? p1_wEn    : p0_wEn;
            ram_addr   <= pick ? p1_addr   : p0_addr;
            ram_dataIn <= pick ? p1_dataIn : p0_dataIn;
          end else begin
            ram_wEn <= 1'b0;
          end
        end
        ACCESS: begin
          // RAM updated dataOut on the negedge inside this cycle
          ram_wEn <= 1'b0;
          if (winner == PORT1) begin
            p1_ack <= 1'b1;
            if (!ram_wEn) p1_dataOut <= ram_dataOut;
          end else begin
            p0_ack <= 1'b1;
            if (!ram_wEn) p0_dataOut <= ram_dataOut;
          end
        end
        ACK: begin
          p0_ack <= 1'b0;
          p1_ack <= 1'b0;
        end
        default: begin
          ram_wEn <= 1'b0;
          p0_ack  <= 1'b0;
          p1_ack  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench: round-robin arbiter on a behavioural RAM plus a fixed-priority instance.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Instance A: round-robin, backed by a RAM model that updates on negedge
  logic [1:0]       a_req, a_wen, a_ack;
  logic [1:0][11:0] a_addr;
  logic [1:0][31:0] a_din, a_dout;
  logic             a_rwe, a_busy;
  logic [11:0]      a_raddr;
  logic [31:0]      a_rdi, a_rdo;
  logic [31:0]      mem_a [0:4095];

  always @(negedge clk) begin
    if (a_rwe) mem_a[a_raddr] <= a_rdi;
    a_rdo <= mem_a[a_raddr];
  end

  ram_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12), .FIXED_PRIO(0)) dut_a (
    .clk(clk), .reset(reset),
    .p0_req(a_req[0]), .p0_wEn(a_wen[0]), .p0_addr(a_addr[0]), .p0_dataIn(a_din[0]),
    .p0_ack(a_ack[0]), .p0_dataOut(a_dout[0]),
    .p1_req(a_req[1]), .p1_wEn(a_wen[1]), .p1_addr(a_addr[1]), .p1_dataIn(a_din[1]),
    .p1_ack(a_ack[1]), .p1_dataOut(a_dout[1]),
    .ram_wEn(a_rwe), .ram_addr(a_raddr), .ram_dataIn(a_rdi), .ram_dataOut(a_rdo),
    .busy(a_busy)
  );

  // Instance B: fixed priority; RAM returns the address as data
  logic [1:0]       b_req, b_wen, b_ack;
  logic [1:0][11:0] b_addr;
  logic [1:0][31:0] b_din, b_dout;
  logic             b_rwe, b_busy;
  logic [11:0]      b_raddr;
  logic [31:0]      b_rdi, b_rdo;

  always @(negedge clk) b_rdo <= {20'd0, b_raddr};

  ram_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12), .FIXED_PRIO(1)) dut_b (
    .clk(clk), .reset(reset),
    .p0_req(b_req[0]), .p0_wEn(b_wen[0]), .p0_addr(b_addr[0]), .p0_dataIn(b_din[0]),
    .p0_ack(b_ack[0]), .p0_dataOut(b_dout[0]),
    .p1_req(b_req[1]), .p1_wEn(b_wen[1]), .p1_addr(b_addr[1]), .p1_dataIn(b_din[1]),
    .p1_ack(b_ack[1]), .p1_dataOut(b_dout[1]),
    .ram_wEn(b_rwe), .ram_addr(b_raddr), .ram_dataIn(b_rdi), .ram_dataOut(b_rdo),
    .busy(b_busy)
  );

  typedef struct {
    bit          port;
    bit          we;
    logic [11:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t             vecs [8];
  logic [1:0][31:0] mdout;
  bit               lg;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One transaction on instance A; starts just after a posedge
  task automatic txn_a(input bit p, input bit we, input logic [11:0] ad,
                       input logic [31:0] d, input logic [31:0] exp, input string nm);
    int lat, wcnt;
    bit got;
    lat = 0; wcnt = 0; got = 0;
    a_req[p] = 1'b1; a_wen[p] = we; a_addr[p] = ad; a_din[p] = d;
    for (int i = 1; i <= 8 && !got; i++) begin
      @(posedge clk); #2;
      if (a_rwe) begin
        wcnt++;
        chk({nm, "_waddr"}, {20'd0, a_raddr}, {20'd0, ad});
        chk({nm, "_wdata"}, a_rdi, d);
      end
      chk({nm, "_other_ack"}, {31'd0, a_ack[!p]}, 32'd0);
      if (a_ack[p]) begin got = 1; lat = i; end
    end
    chk({nm, "_latency"}, lat, 2);
    chk({nm, "_wen_cycles"}, wcnt, {31'd0, we});
    if (!we) mdout[p] = exp;
    chk({nm, "_dout"}, a_dout[p], mdout[p]);
    lg = p;
    a_req[p] = 1'b0;
    @(posedge clk); #2;
    chk({nm, "_ack_drop"}, {31'd0, a_ack[p]}, 32'd0);
    chk({nm, "_idle"}, {31'd0, a_busy}, 32'd0);
    chk({nm, "_dout_hold"}, a_dout[p], mdout[p]);
  endtask

  // Reset asserted inside ACCESS, before the RAM negedge
  task automatic abort_a(input bit we, input logic [11:0] ad, input logic [31:0] d, input string nm);
    a_req[0] = 1'b1; a_wen[0] = we; a_addr[0] = ad; a_din[0] = d;
    @(posedge clk); #1;
    chk({nm, "_in_access"}, {31'd0, a_busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk({nm, "_busy"}, {31'd0, a_busy}, 32'd0);
    chk({nm, "_wen"}, {31'd0, a_rwe}, 32'd0);
    chk({nm, "_dout0"}, a_dout[0], 32'd0);
    a_req[0] = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_no_ack"}, {30'd0, a_ack}, 32'd0);
    reset = 1'b0;
    mdout = '0;
    lg = 1'b1;
  endtask

  initial begin
    int n_ack, n0, p1_got, p1_early, last_cyc, cyc;
    bit exp_p;

    vecs[0] = '{0, 1, 12'd5,    32'hDEADBEEF, 32'h0};
    vecs[1] = '{1, 0, 12'd5,    32'h0,        32'hDEADBEEF};
    vecs[2] = '{1, 1, 12'd1001, 32'd1500,     32'h0};
    vecs[3] = '{0, 0, 12'd1001, 32'h0,        32'd1500};
    vecs[4] = '{0, 1, 12'hFFF,  32'hFFFFFFFF, 32'h0};
    vecs[5] = '{1, 0, 12'hFFF,  32'h0,        32'hFFFFFFFF};
    vecs[6] = '{1, 1, 12'd7,    32'h0000AAAA, 32'h0};
    vecs[7] = '{0, 0, 12'd7,    32'h0,        32'h0000AAAA};

    a_req = '0; a_wen = '0; a_addr = '0; a_din = '0;
    b_req = '0; b_wen = '0; b_addr = '0; b_din = '0;
    mdout = '0; lg = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_wen", {31'd0, a_rwe}, 32'd0);
    chk("rst_addr", {20'd0, a_raddr}, 32'd0);
    chk("rst_din", a_rdi, 32'd0);
    chk("rst_ack", {28'd0, b_ack, a_ack}, 32'd0);
    chk("rst_dout0", a_dout[0], 32'd0);
    chk("rst_dout1", a_dout[1], 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      txn_a(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].exp,
            $sformatf("vec%0d", i));
    chk("pwm1_reg", mem_a[PWM_BASE + 12'd1], 32'd1500);

    // Round-robin contention, both requests held
    a_wen = '0; a_addr[0] = 12'd1001; a_addr[1] = 12'd5;
    a_req = 2'b11;
    n_ack = 0; last_cyc = 0; exp_p = !lg;
    for (cyc = 1; cyc <= 30 && n_ack < 4; cyc++) begin
      @(posedge clk); #2;
      chk("rr_overlap", {31'd0, a_ack[0] & a_ack[1]}, 32'd0);
      if (a_ack != 2'b00) begin
        chk($sformatf("rr_grant%0d", n_ack), {30'd0, a_ack}, exp_p ? 32'd2 : 32'd1);
        chk($sformatf("rr_dout%0d", n_ack), a_dout[exp_p], exp_p ? 32'hDEADBEEF : 32'd1500);
        if (n_ack > 0) chk($sformatf("rr_gap%0d", n_ack), cyc - last_cyc, 3);
        last_cyc = cyc;
        exp_p = !exp_p;
        n_ack++;
      end
    end
    chk("rr_count", n_ack, 4);
    a_req = 2'b00;
    @(posedge clk); #1;
    lg = !exp_p;

    // Fixed priority: p0 keeps re-requesting; p1 waits until p0 lets go
    b_addr[0] = 12'h010; b_addr[1] = 12'h020;
    b_req = 2'b11;
    n0 = 0; p1_got = 0; p1_early = 0;
    for (cyc = 1; cyc <= 30 && p1_got == 0; cyc++) begin
      @(posedge clk); #2;
      if (b_ack[1]) begin
        p1_got = 1;
        if (n0 < 3) p1_early++;
      end
      if (b_ack[0]) begin
        n0++;
        if (n0 == 3) b_req[0] = 1'b0;
      end
    end
    chk("fp_p0_count", n0, 3);
    chk("fp_p1_early", p1_early, 0);
    chk("fp_p1_served", p1_got, 1);
    chk("fp_dout0", b_dout[0], 32'h010);
    chk("fp_dout1", b_dout[1], 32'h020);
    b_req = 2'b00;
    @(posedge clk); #1;

    abort_a(1'b0, 12'd5, 32'h0, "abort_rd");
    txn_a(0, 0, 12'd5, 32'h0, 32'hDEADBEEF, "post_rd");
    abort_a(1'b1, 12'd7, 32'h00005555, "abort_wr");
    txn_a(0, 0, 12'd7, 32'h0, 32'h0000AAAA, "post_wr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
